// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - parametrised single-clock FIFO with occupancy, thresholds, FWFT mode and sticky errors
module fifo_level #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int FWFT   = 0,
  parameter int AFULL  = 2**AW-1,
  parameter int AEMPTY = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clr,
  input  logic [DW-1:0] i_dat,
  input  logic          i_push,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_afull,
  output logic          o_aempty,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_udf
);

  localparam int          DEPTH     = 2**AW;
  localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL  = (AW+1)'(AFULL);
  localparam logic [AW:0] LP_AEMPTY = (AW+1)'(AEMPTY);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_idx;
  logic [AW-1:0] r_wr_idx;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_udf;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_wr_en;
  logic w_rd_en;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign w_push_ok = i_push & (~w_full | i_pop);
  assign w_pop_ok  = i_pop & ~w_empty;
  assign w_wr_en   = w_push_ok & ~i_clr & i_reset_n;
  assign w_rd_en   = w_pop_ok & ~i_clr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (i_clr) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_idx <= r_wr_idx + AW'(1);
      if (w_pop_ok)  r_rd_idx <= r_rd_idx + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) r_ovf <= 1'b1;
      if (i_pop && !w_pop_ok)   r_udf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_idx] <= i_dat;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_dat = r_mem[r_rd_idx];
    end else begin : g_reg
      logic [DW-1:0] r_dat;
      // Holds the last popped word; flush leaves it untouched.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)   r_dat <= '0;
        else if (w_rd_en) r_dat <= r_mem[r_rd_idx];
      end
      assign o_dat = r_dat;
    end
  endgenerate

  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_afull  = (r_count >= LP_AFULL);
  assign o_aempty = (r_count <= LP_AEMPTY);
  assign o_count  = r_count;
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - scoreboard bench for fifo_level, registered and FWFT instances driven in lockstep
module tb_fifo_level;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dat0, dat1;
  logic       empty0, full0, afull0, aempty0, ovf0, udf0;
  logic       empty1, full1, afull1, aempty1, ovf1, udf1;
  logic [2:0] count0, count1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  always #5 clk = ~clk;

  fifo_level #(.DW(8), .AW(2), .FWFT(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(clr), .i_dat(din),
    .i_push(push), .i_pop(pop), .o_dat(dat0), .o_empty(empty0),
    .o_full(full0), .o_afull(afull0), .o_aempty(aempty0),
    .o_count(count0), .o_ovf(ovf0), .o_udf(udf0)
  );

  fifo_level #(.DW(8), .AW(2), .FWFT(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(clr), .i_dat(din),
    .i_push(push), .i_pop(pop), .o_dat(dat1), .o_empty(empty1),
    .o_full(full1), .o_afull(afull1), .o_aempty(aempty1),
    .o_count(count1), .o_ovf(ovf1), .o_udf(udf1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Status of both instances against the queue model.
  task automatic chk_status();
    int n;
    n = q.size();
    chk("count0", 32'(count0), 32'(n));
    chk("count1", 32'(count1), 32'(n));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("full0", 32'(full0), 32'(n == DEPTH));
    chk("full1", 32'(full1), 32'(n == DEPTH));
    chk("afull0", 32'(afull0), 32'(n >= 3));
    chk("afull1", 32'(afull1), 32'(n >= 3));
    chk("aempty0", 32'(aempty0), 32'(n <= 1));
    chk("aempty1", 32'(aempty1), 32'(n <= 1));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("udf0", 32'(udf0), 32'(m_udf));
    chk("udf1", 32'(udf1), 32'(m_udf));
    if (n != 0) chk("fwft_head", 32'(dat1), 32'(q[0]));
  endtask

  task automatic cycle(input bit p_push, input bit p_pop, input bit p_clr, input logic [7:0] d);
    bit push_ok, pop_ok;
    @(negedge clk);
    push = p_push; pop = p_pop; clr = p_clr; din = d;
    if (p_clr) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      push_ok = p_push && (q.size() < DEPTH || p_pop);
      pop_ok  = p_pop && q.size() != 0;
      if (pop_ok) begin
        sb0.push_back(q[0]);
        sb1.push_back(q[0]);
        void'(q.pop_front());
      end
      if (push_ok) q.push_back(d);
      if (p_push && !push_ok) m_ovf = 1;
      if (p_pop && !pop_ok)   m_udf = 1;
    end
    @(posedge clk);
    #1;
    chk_status();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count0", 32'(count0), 0);
    chk("rst_count1", 32'(count1), 0);
    chk("rst_empty0", 32'(empty0), 1);
    chk("rst_full0", 32'(full0), 0);
    chk("rst_afull0", 32'(afull0), 0);
    chk("rst_aempty0", 32'(aempty0), 1);
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_udf0", 32'(udf0), 0);
    chk("rst_dat0", 32'(dat0), 0);
    chk("rst_empty1", 32'(empty1), 1);
  endtask

  // Monitor: a pop handshake seen before an edge retires one scoreboard entry.
  // FWFT shows the word before the edge, registered mode one cycle later.
  initial begin : monitor
    bit pend0;
    logic [7:0] e;
    pend0 = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pend0) begin
        if (sb0.size() == 0) chk("sb0_underrun", 1, 0);
        else begin
          e = sb0.pop_front();
          chk("pop_dat0", 32'(dat0), 32'(e));
        end
        pend0 = 0;
      end
      if (rst_n && !clr && pop && !empty0) pend0 = 1;
      if (rst_n && !clr && pop && !empty1) begin
        if (sb1.size() == 0) chk("sb1_underrun", 1, 0);
        else begin
          e = sb1.pop_front();
          chk("pop_dat1", 32'(dat1), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [7:0] fill[4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) cycle(1, 0, 0, fill[i]);
    cycle(1, 0, 0, 8'h55);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'hA5);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);

    for (int i = 0; i < 4; i++) cycle(1, 0, 0, fill[i]);
    cycle(1, 1, 0, 8'h66);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h00);

    cycle(1, 0, 0, 8'h7E);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);

    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'hC0 + 8'(i));
    cycle(0, 0, 0, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 8'h3C);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h90 + 8'(i));
    cycle(0, 0, 1, 8'h00);

    for (int i = 0; i < 2000; i++) begin
      bit rp, rq, rc;
      rp = ($urandom_range(99) < 55);
      rq = ($urandom_range(99) < 50);
      rc = ($urandom_range(99) < 2);
      cycle(rp, rq, rc, 8'($urandom_range(255)));
    end

    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("sb0_drained", 32'(sb0.size()), 0);
    chk("sb1_drained", 32'(sb1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO, successor to the fixed 4-entry byte FIFO used in the UART master path. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It sits between the UART byte engines and the bus-side master logic. It is also intended for reuse as the generic single-clock buffer elsewhere in the simulator.

## Interface
- DW, 8, data width in bits
- AW, 2, address width; depth = 2**AW entries, all usable
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through
- AFULL, 2**AW-1, o_afull threshold (count >= AFULL); legal range 1..2**AW
- AEMPTY, 1, o_aempty threshold (count <= AEMPTY); legal range 0..2**AW-1

- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_clr  in  1  synchronous flush: empties FIFO, clears error flags
- i_dat  in  DW  write data
- i_push  in  1  write request
- i_pop  in  1  read request
- o_dat  out  DW  read data (meaning depends on FWFT)
- o_empty  out  1  count == 0
- o_full  out  1  count == 2**AW
- o_afull  out  1  count >= AFULL
- o_aempty  out  1  count <= AEMPTY
- o_count  out  AW+1  current occupancy, 0..2**AW
- o_ovf  out  1  sticky: a push was rejected
- o_udf  out  1  sticky: a pop was rejected

## Operation
- Storage is 2**AW x DW. rd_idx and wr_idx are AW bits and wrap modulo 2**AW. count is AW+1 bits.
- Push accepted (push_ok) = i_push & (~o_full | i_pop). When full, a simultaneous push+pop is accepted, so count stays 2**AW.
- Pop accepted (pop_ok) = i_pop & ~o_empty. Pop on an empty FIFO is never accepted, even with a simultaneous push.
- push_ok: write buffer[wr_idx] <= i_dat, then wr_idx++.
- pop_ok: rd_idx++.
- count update: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
- i_push & ~push_ok sets o_ovf. i_pop & ~pop_ok sets o_udf. Both flags stay set until i_clr or reset.
- FWFT=0: on a pop_ok edge, o_dat <= buffer[rd_idx] (the popped word). Otherwise o_dat holds its value.
- FWFT=1: o_dat = buffer[rd_idx] continuously. It is valid whenever ~o_empty and is undefined/don't-care when empty. i_pop acknowledges the displayed word.
- i_clr (synchronous) has priority over push/pop. It zeroes rd_idx, wr_idx, count, o_ovf and o_udf. Buffer contents and the FWFT=0 o_dat register are unchanged.
- Asynchronous reset (i_reset_n=0) zeroes rd_idx, wr_idx, count, o_ovf, o_udf and the o_dat register.
- Output values during reset: o_empty=1, o_full=0, o_afull=0 (AFULL>=1), o_aempty=1, o_count=0, o_dat=0 (FWFT=0).
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Flags and o_count are decoded combinationally from the registered count. There is no flag lag relative to o_count.

## Timing
- Push at edge n: o_count, o_empty, o_full, o_afull and o_aempty reflect the new word right after edge n.
- FWFT=1: a word pushed into an empty FIFO at edge n appears on o_dat right after edge n (0 cycles of extra latency).
- FWFT=0: pop asserted in the cycle before edge n; the popped word is on o_dat after edge n (1-cycle latency) and held until the next pop_ok.
- Full to push-accepted turnaround: pop_ok at edge n gives o_full=0 after edge n, so a push alone is accepted at edge n+1.
- Reset release: the first edge with i_reset_n=1 can accept a push.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then push 0x11,0x22,0x33,0x44 (DW=8, AW=2) -> o_count 1..4. o_aempty drops once count reaches 2. o_afull=1 at count 3. o_full=1 at count 4. No o_ovf.
- Full FIFO, push 0x55 alone -> o_ovf=1, count stays 4. Then pop 4 times (FWFT=0) -> o_dat shows 0x11,0x22,0x33,0x44, each one cycle after its pop. o_empty=1 after the 4th pop.
- Empty FIFO, pop alone -> o_udf=1, count 0. Empty FIFO, push 0xA5 + pop in the same cycle -> count=1, o_udf=1, 0xA5 retained.
- Full FIFO, push 0x66 + pop in the same cycle -> count stays 4, o_ovf stays 0. The next 4 pops yield 0x22,0x33,0x44,0x66 (wrap-around verified).
- FWFT=1: push 0x7E into the empty FIFO -> o_dat=0x7E in the next cycle with no pop. Pop -> o_empty=1.
- Async and sync clear: with 3 entries, drop i_reset_n between clock edges -> all outputs go to reset values immediately. Refill, set o_ovf, assert i_clr -> count=0, o_ovf=0 after that edge.
